// File: rtl/controler_pkg.sv
// controler_pkg: command, ULA and register-control encodings plus the FSM state type for seq_controler
package controler_pkg;

  localparam logic [3:0] C_CLR   = 4'd0;
  localparam logic [3:0] C_CLRLD = 4'd1;
  localparam logic [3:0] C_LOADX = 4'd2;
  localparam logic [3:0] C_ADD   = 4'd3;
  localparam logic [3:0] C_SUB   = 4'd4;
  localparam logic [3:0] C_MULT  = 4'd5;
  localparam logic [3:0] C_DIV   = 4'd6;
  localparam logic [3:0] C_MIN   = 4'd7;
  localparam logic [3:0] C_MAX   = 4'd8;
  localparam logic [3:0] C_DISP  = 4'd9;
  localparam logic [3:0] C_END   = 4'd10;

  localparam logic [3:0] U_ADD   = 4'd0;
  localparam logic [3:0] U_SUB   = 4'd1;
  localparam logic [3:0] U_COMP  = 4'd2;
  localparam logic [3:0] U_IGUAL = 4'd3;
  localparam logic [3:0] U_MAIOR = 4'd4;
  localparam logic [3:0] U_MENOR = 4'd5;
  localparam logic [3:0] U_AND   = 4'd6;
  localparam logic [3:0] U_OR    = 4'd7;
  localparam logic [3:0] U_MULT  = 4'd8;
  localparam logic [3:0] U_DIV   = 4'd9;

  localparam logic [2:0] R_HOLD  = 3'd0;
  localparam logic [2:0] R_RESET = 3'd1;
  localparam logic [2:0] R_LOAD  = 3'd2;
  localparam logic [2:0] R_SHL   = 3'd3;
  localparam logic [2:0] R_SHR   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT,
    S_ERR,
    S_HALT
  } state_t;

endpackage

// File: rtl/cmd_decode.sv
// cmd_decode: maps a calculator command to ULA/X/Y/Z controls plus multi-cycle and legality flags
//   cmd      in  4  command code
//   ula      out 4  ULA operation for the execute (or final) cycle
//   x, y, z  out 3  register controls for the execute (or final) cycle
//   is_multi out 1  command is stretched over several cycles (MULT/DIV)
//   is_legal out 1  command code is defined
module cmd_decode
  import controler_pkg::*;
(
  input  logic [3:0] cmd,
  output logic [3:0] ula,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [2:0] z,
  output logic       is_multi,
  output logic       is_legal
);
  always_comb begin
    ula      = U_ADD;
    x        = R_HOLD;
    y        = R_HOLD;
    z        = R_HOLD;
    is_multi = 1'b0;
    is_legal = 1'b1;
    case (cmd)
      C_CLR:   begin x = R_RESET; y = R_RESET; z = R_RESET; end
      C_CLRLD: begin x = R_LOAD; y = R_RESET; z = R_RESET; end
      C_LOADX: x = R_LOAD;
      C_ADD:   begin x = R_LOAD; y = R_LOAD; end
      C_SUB:   begin ula = U_SUB; x = R_LOAD; y = R_LOAD; end
      C_MULT:  begin ula = U_MULT; x = R_LOAD; y = R_LOAD; is_multi = 1'b1; end
      C_DIV:   begin ula = U_DIV; x = R_LOAD; y = R_LOAD; is_multi = 1'b1; end
      C_MIN:   begin ula = U_MENOR; x = R_LOAD; y = R_LOAD; end
      C_MAX:   begin ula = U_MAIOR; x = R_LOAD; y = R_LOAD; end
      C_DISP:  z = R_LOAD;
      C_END:   begin x = R_RESET; y = R_RESET; end
      default: is_legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/seq_controler.sv
// seq_controler: handshaked command sequencer driving ULA and X/Y/Z register controls, with multi-cycle MULT/DIV, HALT and error pulses
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid, cmd    command handshake input (4-bit code)
//   cmd_ready         command accepted when high together with cmd_valid
//   tULA, tX, tY, tZ  registered ULA operation and register controls
//   op_done           pulse on the last execute cycle of an accepted command
//   err               pulse when an illegal or disallowed command is accepted
//   halted            high while halted after END
module seq_controler
  import controler_pkg::*;
#(
  parameter int MULT_CYC = 4,
  parameter int DIV_CYC  = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [3:0] cmd,
  output logic       cmd_ready,
  output logic [3:0] tULA,
  output logic [2:0] tX,
  output logic [2:0] tY,
  output logic [2:0] tZ,
  output logic       op_done,
  output logic       err,
  output logic       halted
);
  logic [3:0] d_ula;
  logic [2:0] d_x, d_y, d_z;
  logic d_multi, d_legal, acc, clr_cmd, last_now;
  logic [CNT_W-1:0] cnt, n_m1;
  state_t state;
  logic end_q, err_halt;

  cmd_decode u_dec (
    .cmd      (cmd),
    .ula      (d_ula),
    .x        (d_x),
    .y        (d_y),
    .z        (d_z),
    .is_multi (d_multi),
    .is_legal (d_legal)
  );

  assign acc      = cmd_valid & cmd_ready;
  assign clr_cmd  = (cmd == C_CLR) || (cmd == C_CLRLD);
  assign n_m1     = (cmd == C_MULT) ? CNT_W'(MULT_CYC - 1) : CNT_W'(DIV_CYC - 1);
  // a multi-cycle op with a single cycle loads X/Y straight away
  assign last_now = (n_m1 == '0);

  // Outputs are registered alongside the state, so every value is computed for the cycle being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      end_q     <= 1'b0;
      err_halt  <= 1'b0;
      cmd_ready <= 1'b1;
      tULA      <= U_ADD;
      tX        <= R_HOLD;
      tY        <= R_HOLD;
      tZ        <= R_HOLD;
      op_done   <= 1'b0;
      err       <= 1'b0;
      halted    <= 1'b0;
    end else begin
      op_done <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (acc) begin
            cmd_ready <= 1'b0;
            halted    <= 1'b0;
            end_q     <= (cmd == C_END);
            err_halt  <= (state == S_HALT);
            if (!d_legal || (state == S_HALT && !clr_cmd)) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else if (d_multi) begin
              state   <= S_WAIT;
              cnt     <= n_m1;
              tULA    <= d_ula;
              tX      <= last_now ? R_LOAD : R_HOLD;
              tY      <= last_now ? R_LOAD : R_HOLD;
              tZ      <= d_z;
              op_done <= last_now;
            end else begin
              state   <= S_EXEC;
              tULA    <= d_ula;
              tX      <= d_x;
              tY      <= d_y;
              tZ      <= d_z;
              op_done <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          state     <= end_q ? S_HALT : S_IDLE;
          halted    <= end_q;
          cmd_ready <= 1'b1;
          tULA      <= U_ADD;
          tX        <= R_HOLD;
          tY        <= R_HOLD;
          tZ        <= R_HOLD;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            tULA      <= U_ADD;
            tX        <= R_HOLD;
            tY        <= R_HOLD;
            tZ        <= R_HOLD;
          end else begin
            cnt     <= cnt - 1'b1;
            tX      <= (cnt == CNT_W'(1)) ? R_LOAD : R_HOLD;
            tY      <= (cnt == CNT_W'(1)) ? R_LOAD : R_HOLD;
            op_done <= (cnt == CNT_W'(1));
          end
        end
        S_ERR: begin
          state     <= err_halt ? S_HALT : S_IDLE;
          halted    <= err_halt;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          halted    <= 1'b0;
        end
      endcase
    end
  end
endmodule
